// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;
    localparam int DEPTH_BUF = 2;
    localparam int XFER_W    = 16;

    typedef logic [XFER_W-1:0] xfer_t;
endpackage

// File: rtl/fifo_rd_stream.sv
// Turns a registered-output FIFO read port into a valid/ready stream through a
// 2-entry skid buffer, sustaining one beat per cycle despite the read latency.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         r_clk,
    input  logic         r_rst_n,
    input  logic         fifo_empty,
    input  logic [W-1:0] fifo_dout,
    output logic         fifo_rd_en,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [1:0]   level,
    output xfer_t        xfer_cnt
);

    logic [1:0]   cnt_q, cnt_d;
    logic         inflight_q;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    xfer_t        xfer_q, xfer_d;

    logic         pop;
    logic [1:0]   post;
    logic [2:0]   occ;

    assign pop = m_valid && m_ready;
    // pop implies cnt_q >= 1, so the subtraction cannot underflow.
    assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = r_rst_n && !fifo_empty && (occ < 3'(DEPTH_BUF));

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        post   = cnt_q - {1'b0, pop};
        if (pop && cnt_q == 2'd2) head_d = tail_q;
        // A returning word goes behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (post == 2'd0) head_d = fifo_dout;
            else              tail_d = fifo_dout;
        end
        cnt_d  = post + {1'b0, inflight_q};
        xfer_d = xfer_q + XFER_W'(pop);
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            xfer_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            xfer_q     <= xfer_d;
        end
    end

    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = head_q;
    assign level    = cnt_q;
    assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: behavioural FIFO with one-cycle read latency feeding the DUT,
// and a scoreboard of expected stream words checked as beats are accepted.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
    localparam int W = 8;

    logic         r_clk = 1'b0;
    logic         r_rst_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [1:0]   level;
    logic [15:0]  xfer_cnt;

    always #5 r_clk = ~r_clk;

    fifo_rd_stream #(.W(W)) dut (
        .r_clk      (r_clk),
        .r_rst_n    (r_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .xfer_cnt   (xfer_cnt)
    );

    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_xfer = '0;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int first_rd, first_vld, first_pop, last_pop, n_rd, n_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic clr_stats();
        first_rd = -1; first_vld = -1; first_pop = -1; last_pop = -1;
        n_rd = 0; n_pop = 0;
    endtask

    // Called just after a falling edge; advances one full cycle.
    task automatic step();
        logic rd, popd;
        logic [W-1:0] d;
        fifo_empty = (fq.size() == 0);
        #1;
        rd   = fifo_rd_en;
        popd = m_valid && m_ready;
        d    = m_data;
        chk("level_max", 32'(level <= 2'd2), 32'd1);
        if (rd) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (popd) begin
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("data", 32'(d), 32'(exp_q.pop_front()));
        end
        @(posedge r_clk);
        #1;
        if (rd) begin
            chk("rd_on_empty", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) fifo_dout = fq.pop_front();
        end
        if (popd && r_rst_n) exp_xfer++;
        chk("xfer", 32'(xfer_cnt), 32'(exp_xfer));
        cyc++;
        @(negedge r_clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int g = 0;
        while ((exp_q.size() != 0 || level != 0) && g < budget) begin
            step();
            g++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] wrap_exp [3];
        int i;
        wrap_exp[0] = 16'hFFFF; wrap_exp[1] = 16'h0000; wrap_exp[2] = 16'h0001;

        // Reset state, then idle with an empty FIFO
        #2;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(negedge r_clk);
        r_rst_n = 1'b1;
        clr_stats();
        repeat (10) step();
        chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_xfer", 32'(xfer_cnt), 32'd0);
        chk("idle_reads", 32'(n_rd), 32'd0);

        // 32 preloaded words, sink always ready
        for (int k = 1; k <= 32; k++) push(W'(k));
        m_ready = 1'b1;
        clr_stats();
        drain("t2_drain", 200);
        chk("t2_latency", 32'(first_vld - first_rd), 32'd2);
        chk("t2_no_bubble", 32'(last_pop - first_pop), 32'd31);
        chk("t2_xfer", 32'(xfer_cnt), 32'd32);

        // Back-pressure: only two reads outstanding
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(W'(8'h30 + k));
        clr_stats();
        repeat (8) step();
        fifo_empty = (fq.size() == 0);
        #1;
        chk("t3_reads", 32'(n_rd), 32'd2);
        chk("t3_level", 32'(level), 32'd2);
        chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("t3_head", 32'(m_data), 32'h30);
        m_ready = 1'b1;
        clr_stats();
        drain("t3_drain", 50);
        chk("t3_beats", 32'(n_pop), 32'd5);
        chk("t3_no_bubble", 32'(last_pop - first_pop), 32'd4);

        // Sink toggling every cycle
        for (int k = 0; k < 16; k++) push(W'(8'h60 + k));
        clr_stats();
        i = 0;
        while ((exp_q.size() != 0 || level != 0) && i < 200) begin
            m_ready = i[0];
            step();
            i++;
        end
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        chk("t4_beats", 32'(n_pop), 32'd16);

        // Mid-operation reset with a read in flight, then with a full buffer
        for (int k = 2; k <= 3; k++) begin
            m_ready = 1'b0;
            for (int j = 0; j < 6; j++) push(W'(8'h80 + 8 * k + j));
            repeat (k) step();
            chk("pre_rst_level", 32'(level), 32'(k - 1));
            r_rst_n = 1'b0;
            #1;
            chk("rst_mid_valid", 32'(m_valid), 32'd0);
            chk("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("rst_mid_level", 32'(level), 32'd0);
            chk("rst_mid_xfer", 32'(xfer_cnt), 32'd0);
            fq.delete();
            exp_q.delete();
            exp_xfer = '0;
            @(negedge r_clk);
            repeat (2) step();
            r_rst_n = 1'b1;
            m_ready = 1'b1;
            for (int j = 0; j < 4; j++) push(W'(8'hC0 + 4 * k + j));
            drain("post_rst_drain", 50);
        end

        // xfer_cnt wrap
        m_ready = 1'b1;
        i = 0;
        while (exp_xfer != 16'hFFFE && i < 70000) begin
            if (fq.size() < 4) push(W'(i));
            step();
            i++;
        end
        chk("wrap_reach", 32'(xfer_cnt), 32'hFFFE);
        m_ready = 1'b0;
        for (int j = 0; j < 4; j++) push(W'(8'hE0 + j));
        repeat (3) step();
        for (int j = 0; j < 3; j++) begin
            m_ready = 1'b1;
            step();
            chk("wrap_val", 32'(xfer_cnt), 32'(wrap_exp[j]));
        end
        drain("final_drain", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
